// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the transmitter and the future receiver.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_TX_BREAK_EN
    , BREAK
`endif
  } tx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Both 00 and 11 on the mode pins mean no parity.
  function automatic parity_mode_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Ready/valid write channel from a byte producer into the UART transmit FIFO.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 i_tx_valid;
  logic                 o_tx_ready;
  logic [DATA_BITS-1:0] i_tx_data;

  modport master (output i_tx_valid, output i_tx_data, input o_tx_ready);
  modport slave  (input i_tx_valid, input i_tx_data, output o_tx_ready);
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO; full/empty derive from the occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       pop,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  // A full FIFO refuses a write even when the same edge also pops.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define validity, so a flush never needs to clear the array.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with integrated FIFO, run-time parity/stop selection latched per frame.
// Optional line-break generation is compiled in with UART_TX_BREAK_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  uart_tx_fifo_if.slave                   tx,
  input  logic [1:0]                      i_parity_mode,
  input  logic                            i_two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic                            i_break,
`endif
  output logic                            o_tx_serial,
  output logic                            o_tx_active,
  output logic                            o_tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fifo_count
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS + 5);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end

  tx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  parity_mode_t         mode_q;
  logic                 two_stop_q;
  logic                 par_q;
  logic                 pop, load, frame_end, bit_end;
  logic                 line_d, active_d;
  logic [DATA_BITS-1:0] head;
  logic                 full, empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tx.i_tx_valid),
    .data_in  (tx.i_tx_data),
    .pop      (pop),
    .data_out (head),
    .full     (full),
    .empty    (empty),
    .count    (o_fifo_count)
  );

  assign tx.o_tx_ready = !full;
  assign bit_end       = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load      = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = START;
        end
`ifdef UART_TX_BREAK_EN
        if (i_break) begin
          pop     = 1'b0;
          load    = 1'b0;
          state_d = BREAK;
        end
`endif
      end
      START:  if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end && bit_idx_q == IDX_W'(DATA_BITS - 1))
          state_d = (mode_q == PAR_NONE) ? STOP : PARITY;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        // bit_idx counts stop periods, so the second stop bit ends at index 1.
        if (bit_end && bit_idx_q == IDX_W'(two_stop_q)) begin
          frame_end = 1'b1;
          state_d   = IDLE;
          if (!empty) begin
            pop     = 1'b1;
            load    = 1'b1;
            state_d = START;
          end
`ifdef UART_TX_BREAK_EN
          if (i_break) begin
            pop     = 1'b0;
            load    = 1'b0;
            state_d = BREAK;
          end
`endif
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: if (bit_end && bit_idx_q == IDX_W'(DATA_BITS + 4)) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    line_d   = 1'b1;
    active_d = (state_q != IDLE);
    case (state_q)
      START:  line_d = 1'b0;
      DATA:   line_d = shreg_q[0];
      PARITY: line_d = par_q;
`ifdef UART_TX_BREAK_EN
      // Low for DATA_BITS+4 periods, then one high recovery period.
      BREAK:  line_d = (bit_idx_q == IDX_W'(DATA_BITS + 4));
`endif
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      mode_q     <= PAR_NONE;
      two_stop_q <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      if (state_q == IDLE || bit_end) cnt_q <= '0;
      else                            cnt_q <= cnt_q + CNT_W'(1);

      if (state_d != state_q) bit_idx_q <= '0;
      else if (bit_end)       bit_idx_q <= bit_idx_q + IDX_W'(1);

      if (load) begin
        shreg_q    <= head;
        mode_q     <= decode_parity(i_parity_mode);
        two_stop_q <= i_two_stop;
        par_q      <= (^head) ^ (decode_parity(i_parity_mode) == PAR_ODD);
      end else if (state_q == DATA && bit_end) begin
        shreg_q <= shreg_q >> 1;
      end
    end
  end

  // Outputs follow the state by one cycle so the line comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_tx_serial <= 1'b1;
      o_tx_active <= 1'b0;
      o_tx_done   <= 1'b0;
    end else begin
      o_tx_serial <= line_d;
      o_tx_active <= active_d;
      o_tx_done   <= frame_end;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: cycle-exact frame waveforms, back-to-back, backpressure, reset, latching.
// Drives i_break low when UART_TX_BREAK_EN is defined.
module tb_uart_tx_fifo;
  localparam int CLK_FREQ   = 50000000;
  localparam int BAUD       = 5000000;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CPB        = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       serial, active, done;
  logic [2:0] fifo_count;
`ifdef UART_TX_BREAK_EN
  logic       brk = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(DATA_BITS)) tx_bus ();

  uart_tx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tx            (tx_bus),
    .i_parity_mode (parity_mode),
    .i_two_stop    (two_stop),
`ifdef UART_TX_BREAK_EN
    .i_break       (brk),
`endif
    .o_tx_serial   (serial),
    .o_tx_active   (active),
    .o_tx_done     (done),
    .o_fifo_count  (fifo_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] pm, input logic ts);
    @(negedge clk);
    tx_bus.i_tx_data  = d;
    tx_bus.i_tx_valid = 1'b1;
    parity_mode       = pm;
    two_stop          = ts;
    @(negedge clk);
    tx_bus.i_tx_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag, output int waited, output bit ok);
    ok     = 1'b0;
    waited = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (serial === 1'b0) begin
        waited = i;
        ok     = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_start_timeout"}, 32'd1, 32'd0);
  endtask

  // Compares every cycle of one frame against the expected bit sequence.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic [1:0] pm,
                             input logic ts, output int waited);
    bit bits[$];
    bit ok;
    int n;
    int line_err, act_err, done_err;
    bits.push_back(1'b0);
    for (int k = 0; k < DATA_BITS; k++) bits.push_back(d[k]);
    if (pm == 2'b01) bits.push_back(^d);
    if (pm == 2'b10) bits.push_back(~^d);
    bits.push_back(1'b1);
    if (ts) bits.push_back(1'b1);
    line_err = 0;
    act_err  = 0;
    done_err = 0;
    wait_start(tag, waited, ok);
    if (!ok) return;
    n = bits.size() * CPB;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (serial !== bits[i / CPB]) line_err++;
      if (active !== 1'b1) act_err++;
      if (done !== (i == n - 1)) done_err++;
    end
    check({tag, "_line_errs"}, line_err, 0);
    check({tag, "_active_errs"}, act_err, 0);
    check({tag, "_done_errs"}, done_err, 0);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_idle_line"}, serial, 1'b1);
    check({tag, "_idle_active"}, active, 1'b0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] bp_words [6];
    bit         bp_ready [6];
    int         w, w2, w3;
    bit         ok;

    bp_words = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    bp_ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tx_bus.i_tx_valid = 1'b0;
    tx_bus.i_tx_data  = '0;
    parity_mode       = 2'b00;
    two_stop          = 1'b0;
    rst               = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_line", serial, 1'b1);
    check("rst_active", active, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", tx_bus.o_tx_ready, 1'b1);
    check("rst_count", fifo_count, 3'd0);
    rst = 1'b0;

    push(8'hA5, 2'b00, 1'b0);
    check_frame("a5", 8'hA5, 2'b00, 1'b0, w);
    check("a5_latency", w, 2);
    idle_check("a5");

    push(8'h07, 2'b01, 1'b0);
    check_frame("even07", 8'h07, 2'b01, 1'b0, w);
    idle_check("even07");
    push(8'h07, 2'b10, 1'b0);
    check_frame("odd07", 8'h07, 2'b10, 1'b0, w);
    idle_check("odd07");

    fork
      begin
        push(8'h11, 2'b00, 1'b1);
        push(8'h22, 2'b00, 1'b1);
        push(8'h33, 2'b00, 1'b1);
      end
      begin
        check_frame("b2b1", 8'h11, 2'b00, 1'b1, w);
        check_frame("b2b2", 8'h22, 2'b00, 1'b1, w2);
        check_frame("b2b3", 8'h33, 2'b00, 1'b1, w3);
        check("b2b2_gap", w2, 1);
        check("b2b3_gap", w3, 1);
      end
    join
    idle_check("b2b");
    check("b2b_count", fifo_count, 3'd0);

    parity_mode = 2'b00;
    two_stop    = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          tx_bus.i_tx_data  = bp_words[k];
          tx_bus.i_tx_valid = 1'b1;
          check($sformatf("bp_ready%0d", k), tx_bus.o_tx_ready, bp_ready[k]);
        end
        @(negedge clk);
        tx_bus.i_tx_valid = 1'b0;
        check("bp_full_count", fifo_count, 3'd4);
      end
      begin
        for (int j = 0; j < 5; j++) begin
          check_frame($sformatf("bp%0d", j), bp_words[j], 2'b00, 1'b0, w);
          if (j > 0) check($sformatf("bp%0d_gap", j), w, 1);
        end
      end
    join
    idle_check("bp");
    check("bp_count", fifo_count, 3'd0);

    fork
      begin
        push(8'h52, 2'b00, 1'b0);
        push(8'hC3, 2'b00, 1'b0);
      end
      begin
        wait_start("rst_mid", w, ok);
        repeat (45) @(negedge clk);
        check("rst_mid_pre_line", serial, 1'b0);
        check("rst_mid_pre_count", fifo_count, 3'd1);
      end
    join
    rst = 1'b1;
    #1;
    check("rst_mid_line", serial, 1'b1);
    check("rst_mid_count", fifo_count, 3'd0);
    check("rst_mid_ready", tx_bus.o_tx_ready, 1'b1);
    check("rst_mid_active", active, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(8'h3C, 2'b00, 1'b0);
    check_frame("post_rst", 8'h3C, 2'b00, 1'b0, w);
    check("post_rst_latency", w, 2);
    idle_check("post_rst");

    push(8'h07, 2'b01, 1'b0);
    fork
      begin
        repeat (30) @(negedge clk);
        parity_mode = 2'b10;
        two_stop    = 1'b1;
      end
      check_frame("latch", 8'h07, 2'b01, 1'b0, w);
    join
    idle_check("latch");
    check("final_count", fifo_count, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
